thermostat_temp_classifier: RTL and testbench

//   Upstream stage of the thermostat controller. Turns raw temperature samples into
//   the too_cold / too_hot request levels that the heater/aircon/fan decoder consumes.

---
 rtl/thermostat_temp_classifier_if.sv | 23 ++
 rtl/thermostat_temp_classifier.sv | 136 +++++++++++++
 tb/tb_thermostat_temp_classifier.sv | 120 ++++++++++++
 3 files changed

// File: rtl/thermostat_temp_classifier_if.sv
// Sample/setpoint bus into the temperature classifier and its request/fault levels out.
interface thermostat_temp_classifier_if #(
    parameter int TEMP_W = 8
);
    logic                     temp_valid;
    logic signed [TEMP_W-1:0] temp;
    logic signed [TEMP_W-1:0] setpoint;
    logic                     too_cold;
    logic                     too_hot;
    logic                     sensor_fault;

    // Sensor / setpoint source side
    modport master (
        output temp_valid, temp, setpoint,
        input  too_cold, too_hot, sensor_fault
    );

    // Classifier side
    modport slave (
        input  temp_valid, temp, setpoint,
        output too_cold, too_hot, sensor_fault
    );
endinterface

// File: rtl/thermostat_temp_classifier.sv
// Thermostat temperature classifier: setpoint compare with hysteresis, per-sample
// debounce, and a sensor watchdog that forces both requests low on a fault.
module thermostat_temp_classifier #(
    parameter int TEMP_W   = 8,
    parameter int HYST     = 2,
    parameter int DEBOUNCE = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    thermostat_temp_classifier_if.slave   bus
);
    localparam int EXT_W = TEMP_W + 2;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]        CNT_DONE = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
    localparam logic [WD_W-1:0]         WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]         WD_TRIP  = WD_W'(TIMEOUT - 1);
    localparam logic signed [EXT_W-1:0] HYST_X   = EXT_W'(HYST);

    typedef enum logic [1:0] {
        ST_COMFORT = 2'd0,
        ST_COLD    = 2'd1,
        ST_HOT     = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_dir_hot, w_dir_hot_nxt;   // direction being debounced in COMFORT
    logic [WD_W-1:0]   r_wd, w_wd_nxt;
    logic              r_too_cold, r_too_hot, r_sensor_fault;
    logic              w_cold_nxt, w_hot_nxt, w_fault_nxt;

    // Two guard bits keep setpoint +/- HYST exact across the full signed range.
    logic signed [EXT_W-1:0] w_temp_x, w_sp_x, w_lo, w_hi;
    logic                    w_cold_in, w_cold_out, w_hot_in, w_hot_out;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_wd_trip;

    assign w_temp_x   = {{2{bus.temp[TEMP_W-1]}}, bus.temp};
    assign w_sp_x     = {{2{bus.setpoint[TEMP_W-1]}}, bus.setpoint};
    assign w_lo       = w_sp_x - HYST_X;
    assign w_hi       = w_sp_x + HYST_X;
    assign w_cold_in  = w_temp_x <  w_lo;
    assign w_cold_out = w_temp_x >= w_sp_x;
    assign w_hot_in   = w_temp_x >  w_hi;
    assign w_hot_out  = w_temp_x <= w_sp_x;
    assign w_cnt_inc  = r_cnt + CNT_ONE;
    // The idle cycle that would bring wd to TIMEOUT is the one that trips the fault.
    assign w_wd_trip  = !bus.temp_valid && (r_wd >= WD_TRIP);

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_COMFORT;
            r_cnt          <= '0;
            r_dir_hot      <= 1'b0;
            r_wd           <= '0;
            r_too_cold     <= 1'b0;
            r_too_hot      <= 1'b0;
            r_sensor_fault <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_dir_hot      <= w_dir_hot_nxt;
            r_wd           <= w_wd_nxt;
            r_too_cold     <= w_cold_nxt;
            r_too_hot      <= w_hot_nxt;
            r_sensor_fault <= w_fault_nxt;
        end
    end

    // Next state: watchdog first, then debounce on valid samples only
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_dir_hot_nxt = r_dir_hot;
        w_wd_nxt      = r_wd;

        if (bus.temp_valid)
            w_wd_nxt = '0;
        else if (r_wd != WD_MAX)
            w_wd_nxt = r_wd + WD_W'(1);

        if (w_wd_trip) begin
            w_state_nxt = ST_FAULT;
            w_cnt_nxt   = '0;
        end else if (bus.temp_valid) begin
            case (r_state)
                ST_COMFORT: begin
                    if (w_cold_in || w_hot_in) begin
                        // A direction change restarts the count at this sample.
                        w_dir_hot_nxt = w_hot_in;
                        w_cnt_nxt     = (r_dir_hot == w_hot_in) ? w_cnt_inc : CNT_ONE;
                        if (w_cnt_nxt == CNT_DONE) begin
                            w_state_nxt = w_hot_in ? ST_HOT : ST_COLD;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                ST_COLD, ST_HOT: begin
                    if ((r_state == ST_COLD) ? w_cold_out : w_hot_out) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_DONE) begin
                            w_state_nxt = ST_COMFORT;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: begin
                    // Recovery sample only re-arms; it does not count toward debounce.
                    w_state_nxt = ST_COMFORT;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode of the next state so the levels register with the state
    always_comb begin
        w_cold_nxt  = (w_state_nxt == ST_COLD);
        w_hot_nxt   = (w_state_nxt == ST_HOT);
        w_fault_nxt = (w_state_nxt == ST_FAULT);
    end

    assign bus.too_cold     = r_too_cold;
    assign bus.too_hot      = r_too_hot;
    assign bus.sensor_fault = r_sensor_fault;
endmodule

// File: tb/tb_thermostat_temp_classifier.sv
// Scoreboard bench for the thermostat temperature classifier (default parameters).
module tb_thermostat_temp_classifier;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    logic [2:0] exp_q[$];   // {too_cold, too_hot, sensor_fault}
    string      tag_q[$];

    thermostat_temp_classifier_if #(.TEMP_W(8)) bus ();

    thermostat_temp_classifier #(
        .TEMP_W(8), .HYST(2), .DEBOUNCE(3), .TIMEOUT(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] act, input logic [2:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {cold,hot,fault}=%b expected %b", tag, act, exp);
        end
    endtask

    // Drive one cycle, queue the expected outputs after its edge, then compare.
    task automatic step(input string tag, input logic v, input int t, input logic [2:0] e);
        logic [2:0] exp;
        string      tg;
        bus.temp_valid = v;
        bus.temp       = 8'(t);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        tg  = tag_q.pop_front();
        check(tg, {bus.too_cold, bus.too_hot, bus.sensor_fault}, exp);
    endtask

    task automatic rep(input string tag, input int n, input logic v, input int t,
                       input logic [2:0] e_mid, input logic [2:0] e_last);
        for (int i = 0; i < n; i++)
            step(tag, v, t, (i == n - 1) ? e_last : e_mid);
    endtask

    task automatic do_reset(input string tag);
        reset          = 1'b1;
        bus.temp_valid = 1'b0;
        @(posedge clk);
        #1;
        check(tag, {bus.too_cold, bus.too_hot, bus.sensor_fault}, 3'b000);
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.temp_valid = 1'b0;
        bus.temp       = '0;
        bus.setpoint   = 8'sd20;
        @(posedge clk);
        do_reset("reset");

        // T1: enter COLD on the 3rd sample, leave after three at setpoint
        rep("t1_cold", 3, 1, 17, 3'b000, 3'b100);
        rep("t1_exit", 3, 1, 20, 3'b100, 3'b000);

        // T2: a non-qualifying 19 clears the count; idle gaps hold it
        step("t2_a", 1, 17, 3'b000);
        step("t2_b", 1, 17, 3'b000);
        step("t2_clr", 1, 19, 3'b000);
        step("t2_c", 1, 17, 3'b000);
        rep("t2_gap", 3, 0, 0, 3'b000, 3'b000);
        step("t2_d", 1, 17, 3'b000);
        rep("t2_gap2", 2, 0, 0, 3'b000, 3'b000);
        step("t2_cold", 1, 17, 3'b100);
        rep("t2_exit", 3, 1, 20, 3'b100, 3'b000);

        // T3: hysteresis edges do not qualify; 23 enters HOT, 20 x3 leaves
        rep("t3_18", 10, 1, 18, 3'b000, 3'b000);
        rep("t3_22", 10, 1, 22, 3'b000, 3'b000);
        rep("t3_hot", 3, 1, 23, 3'b000, 3'b010);
        rep("t3_21", 2, 1, 21, 3'b010, 3'b010);
        rep("t3_exit", 3, 1, 20, 3'b010, 3'b000);

        // T4: COLD -> COMFORT -> HOT needs two fresh runs of three
        rep("t4_cold", 3, 1, 17, 3'b000, 3'b100);
        rep("t4_comf", 3, 1, 25, 3'b100, 3'b000);
        rep("t4_hot", 3, 1, 25, 3'b000, 3'b010);
        rep("t4_back", 3, 1, 20, 3'b010, 3'b000);
        rep("t4_cold2", 3, 1, 17, 3'b000, 3'b100);

        // T5: 16 idle cycles trip the watchdog; recovery sample is not counted
        rep("t5_idle", 15, 0, 0, 3'b100, 3'b100);
        step("t5_fault", 0, 0, 3'b001);
        rep("t5_hold", 2, 0, 0, 3'b001, 3'b001);
        step("t5_recov", 1, 17, 3'b000);
        rep("t5_cold", 3, 1, 17, 3'b000, 3'b100);
        rep("t5_exit", 3, 1, 20, 3'b100, 3'b000);

        // T6: full-range extremes, setpoint changing alongside samples
        bus.setpoint = -8'sd128;
        rep("t6_hot", 3, 1, 127, 3'b000, 3'b010);
        bus.setpoint = 8'sd127;
        rep("t6_hexit", 3, 1, -128, 3'b010, 3'b000);
        rep("t6_cold", 3, 1, -128, 3'b000, 3'b100);
        do_reset("t6_rst1");
        rep("t6_part", 2, 1, -128, 3'b000, 3'b000);
        do_reset("t6_rst2");
        rep("t6_fresh", 3, 1, -128, 3'b000, 3'b100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
